// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: function codes and FSM states.
package alu_pkg;
  localparam logic [1:0] FUN_ADD = 2'b00;
  localparam logic [1:0] FUN_SUB = 2'b01;
  localparam logic [1:0] FUN_AND = 2'b10;
  localparam logic [1:0] FUN_XOR = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
endpackage

// File: rtl/alu_sched_if.sv
// Request/response bundle between two requesters, one consumer and the ALU scheduler.
interface alu_sched_if #(parameter int W = 64);
  logic                req0_valid, req1_valid;
  logic                req0_ready, req1_ready;
  logic [1:0]          req0_fun, req1_fun;
  logic signed [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic                req0_setcc;
  logic                rsp_valid, rsp_ready, rsp_id;
  logic signed [W-1:0] rsp_result;
  logic                rsp_of;
  logic                cc_zf, cc_sf, cc_of;

  modport slave (
    input  req0_valid, req1_valid, req0_fun, req1_fun,
           req0_a, req0_b, req1_a, req1_b, req0_setcc, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_of,
           cc_zf, cc_sf, cc_of
  );

  modport master (
    output req0_valid, req1_valid, req0_fun, req1_fun,
           req0_a, req0_b, req1_a, req1_b, req0_setcc, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_of,
           cc_zf, cc_sf, cc_of
  );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU: add/sub with signed overflow, bitwise and/xor.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [1:0]          fun,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] result,
  output logic                of
);
  function automatic logic add_ovf(input logic signed [W-1:0] x, y, r);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [W-1:0] x, y, r);
    return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  always_comb begin
    result = '0;
    of     = 1'b0;
    unique case (fun)
      FUN_ADD: begin
        result = a + b;
        of     = add_ovf(a, b, result);
      end
      FUN_SUB: begin
        result = a - b;
        of     = sub_ovf(a, b, result);
      end
      FUN_AND: result = a & b;
      FUN_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/alu_sched.sv
// Two-requester round-robin ALU scheduler (IDLE -> EXEC -> DONE).
// Optional condition-code register enabled by defining ALU_SCHED_CC_EN.
module alu_sched
  import alu_pkg::*;
#(
  parameter int W = 64
) (
  input logic       clk,
  input logic       rst,
  alu_sched_if.slave bus
);
  state_e              state_q, state_d;
  logic                prio_q, prio_d;
  logic [1:0]          fun_q, fun_d;
  logic signed [W-1:0] a_q, a_d, b_q, b_d;
  logic                id_q, id_d;
  logic signed [W-1:0] result_q, result_d;
  logic                of_q, of_d;
  logic signed [W-1:0] core_result;
  logic                core_of;
  logic                grant0, grant1;

  alu_core #(.W(W)) u_core (
    .fun    (fun_q),
    .a      (a_q),
    .b      (b_q),
    .result (core_result),
    .of     (core_of)
  );

  // prio_q == 0 favours requester 0 when both are valid
  assign grant0 = bus.req0_valid && (!bus.req1_valid || !prio_q);
  assign grant1 = bus.req1_valid && !grant0;

  always_comb begin
    state_d        = state_q;
    prio_d         = prio_q;
    fun_d          = fun_q;
    a_d            = a_q;
    b_d            = b_q;
    id_d           = id_q;
    result_d       = result_q;
    of_d           = of_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rst && (grant0 || grant1)) begin
          bus.req0_ready = grant0;
          bus.req1_ready = grant1;
          fun_d          = grant0 ? bus.req0_fun : bus.req1_fun;
          a_d            = grant0 ? bus.req0_a : bus.req1_a;
          b_d            = grant0 ? bus.req0_b : bus.req1_b;
          id_d           = grant1;
          prio_d         = grant0;
          state_d        = EXEC;
        end
      end
      EXEC: begin
        result_d = core_result;
        of_d     = core_of;
        state_d  = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      id_q     <= 1'b0;
      result_q <= '0;
      of_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      id_q     <= id_d;
      result_q <= result_d;
      of_q     <= of_d;
    end
    fun_q <= fun_d;
    a_q   <= a_d;
    b_q   <= b_d;
  end

  assign bus.rsp_valid  = (state_q == DONE);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_of     = of_q;

`ifdef ALU_SCHED_CC_EN
  logic setcc_q, setcc_d;
  logic cc_zf_q, cc_zf_d, cc_sf_q, cc_sf_d, cc_of_q, cc_of_d;

  // Only requester 0 can ask for a flag update, captured with its grant
  always_comb begin
    setcc_d = (state_q == IDLE && bus.req0_ready) ? bus.req0_setcc : setcc_q;
    cc_zf_d = cc_zf_q;
    cc_sf_d = cc_sf_q;
    cc_of_d = cc_of_q;
    if (state_q == EXEC && !id_q && setcc_q) begin
      cc_zf_d = (core_result == '0);
      cc_sf_d = core_result[W-1];
      cc_of_d = core_of;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      setcc_q <= 1'b0;
      cc_zf_q <= 1'b0;
      cc_sf_q <= 1'b0;
      cc_of_q <= 1'b0;
    end else begin
      setcc_q <= setcc_d;
      cc_zf_q <= cc_zf_d;
      cc_sf_q <= cc_sf_d;
      cc_of_q <= cc_of_d;
    end
  end

  assign bus.cc_zf = cc_zf_q;
  assign bus.cc_sf = cc_sf_q;
  assign bus.cc_of = cc_of_q;
`else
  logic setcc_unused;
  assign setcc_unused = bus.req0_setcc;
  assign bus.cc_zf    = 1'b0;
  assign bus.cc_sf    = 1'b0;
  assign bus.cc_of    = 1'b0;
`endif
endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: vector table, round-robin, stall and reset sequences.
module tb_alu_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_sched_if #(.W(64)) bus ();
  alu_sched #(.W(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit          id;
    logic [1:0]  fun;
    logic [63:0] a, b;
    bit          setcc;
    logic [63:0] r;
    bit          o;
  } vec_t;

  typedef struct {
    bit          id;
    logic [63:0] r;
    bit          o;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];
  exp_t mon_e;
  logic [2:0] exp_cc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t model(input bit id, input logic [1:0] fun, input logic [63:0] a, b);
    logic signed [64:0] wide;
    exp_t e;
    e.id = id;
    e.o  = 1'b0;
    case (fun)
      2'b00: begin
        wide = {a[63], a} + {b[63], b};
        e.r  = wide[63:0];
        e.o  = wide[64] != wide[63];
      end
      2'b01: begin
        wide = {a[63], a} - {b[63], b};
        e.r  = wide[63:0];
        e.o  = wide[64] != wide[63];
      end
      2'b10:   e.r = a & b;
      default: e.r = a ^ b;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp actual=%h required=none", bus.rsp_result);
      end else begin
        mon_e = sbq.pop_front();
        check("rsp_id", bus.rsp_id, mon_e.id);
        check("rsp_result", bus.rsp_result, mon_e.r);
        check("rsp_of", bus.rsp_of, mon_e.o);
      end
    end
  end

  task automatic drive_req(input bit id, input logic [1:0] fun, input logic [63:0] a, b, input bit setcc);
    if (id == 1'b0) begin
      bus.req0_valid = 1'b1; bus.req0_fun = fun; bus.req0_a = a; bus.req0_b = b;
      bus.req0_setcc = setcc;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_fun = fun; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic grant(input bit id, input logic [1:0] fun, input logic [63:0] a, b,
                       input bit setcc, output int waits, output bit ok);
    @(posedge clk); #1;
    drive_req(id, fun, a, b, setcc);
    ok = 1'b0;
    waits = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if ((id == 1'b0 && bus.req0_ready) || (id == 1'b1 && bus.req1_ready)) begin
        ok = 1'b1;
        waits = n;
        break;
      end
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("grant", ok, 1);
  endtask

  // Grants, queues the expectation, then returns at the first DONE cycle.
  task automatic op(input vec_t v, output int waits);
    bit ok;
    int lat;
    grant(v.id, v.fun, v.a, v.b, v.setcc, waits, ok);
    if (!ok) return;
    sbq.push_back('{v.id, v.r, v.o});
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = k;
        break;
      end
    end
    check("latency", lat, 2);
`ifdef ALU_SCHED_CC_EN
    if (v.id == 1'b0 && v.setcc) exp_cc = {v.r == 64'd0, v.r[63], v.o};
`endif
    check("cc", {bus.cc_zf, bus.cc_sf, bus.cc_of}, exp_cc);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    check("rst_ready", {bus.req0_ready, bus.req1_ready}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    sbq.delete();
    exp_cc = 3'b000;
    @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    check("rst_rsp_of", bus.rsp_of, 0);
    check("rst_cc", {bus.cc_zf, bus.cc_sf, bus.cc_of}, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && sbq.size() != 0; k++) @(negedge clk);
    check("drain", sbq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    vec_t v;
    int   waits, ng;
    bit   gseq[4];
    bit   ok, seen;

    vecs[0] = '{0, 2'b00, 64'd5, 64'd7, 1, 64'd12, 0};
    vecs[1] = '{0, 2'b01, 64'h8000_0000_0000_0000, 64'd1, 1, 64'h7FFF_FFFF_FFFF_FFFF, 1};
    vecs[2] = '{1, 2'b11, 64'hFF, 64'hFF, 0, 64'd0, 0};
    vecs[3] = '{0, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'h8000_0000_0000_0000, 1};
    vecs[4] = '{0, 2'b01, 64'd3, 64'd3, 1, 64'd0, 0};
    vecs[5] = '{1, 2'b10, 64'hF0F0, 64'h0FF0, 0, 64'h00F0, 0};
    vecs[6] = '{0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1,
                64'hFFFF_FFFF_FFFF_FFFE, 0};
    vecs[7] = '{1, 2'b01, 64'd0, 64'h8000_0000_0000_0000, 0, 64'h8000_0000_0000_0000, 1};
    vecs[8] = '{0, 2'b11, 64'hAAAA, 64'h5555, 0, 64'hFFFF, 0};
    vecs[9] = '{0, 2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 64'd0, 1};

    rst = 1'b1;
    exp_cc = 3'b000;
    bus.rsp_ready  = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_fun = 2'b00; bus.req0_a = '0; bus.req0_b = '0;
    bus.req0_setcc = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_fun = 2'b00; bus.req1_a = '0; bus.req1_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_reset();

    // Round robin with both requesters continuously valid
    @(posedge clk); #1;
    drive_req(0, 2'b00, 64'd100, 64'd23, 0);
    drive_req(1, 2'b11, 64'hF0, 64'h0F, 0);
    ng = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      @(negedge clk);
      if (bus.req0_ready && bus.req1_ready) check("rr_both_ready", 1, 0);
      if (bus.req0_ready) begin
        gseq[ng] = 1'b0; ng++;
        sbq.push_back(model(0, 2'b00, 64'd100, 64'd23));
      end else if (bus.req1_ready) begin
        gseq[ng] = 1'b1; ng++;
        sbq.push_back(model(1, 2'b11, 64'hF0, 64'h0F));
      end
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("rr_count", ng, 4);
    for (int i = 0; i < ng; i++) check($sformatf("rr_grant%0d", i), gseq[i], i % 2);
    drain();

    for (int i = 0; i < 10; i++) op(vecs[i], waits);
    drain();

    // Consumer stalls for 4 cycles in DONE
    bus.rsp_ready = 1'b0;
    v = '{1, 2'b00, 64'd10, 64'd20, 0, 64'd30, 0};
    op(v, waits);
    @(posedge clk); #1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_valid", bus.rsp_valid, 1);
      check("stall_result", bus.rsp_result, 64'd30);
      check("stall_ready", {bus.req0_ready, bus.req1_ready}, 0);
    end
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    @(negedge clk);
    check("done_no_grant", bus.req0_ready, 0);
    v = '{0, 2'b01, 64'd50, 64'd8, 1, 64'd42, 0};
    op(v, waits);
    check("idle_next", waits, 0);
    drain();

    // Reset during EXEC discards the op and restores priority to requester 0
    grant(0, 2'b00, 64'd1, 64'd1, 1, waits, ok);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cc = 3'b000;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("rst_exec_no_rsp", seen, 0);
    check("rst_exec_cc", {bus.cc_zf, bus.cc_sf, bus.cc_of}, 0);
    @(posedge clk); #1;
    drive_req(0, 2'b00, 64'd2, 64'd3, 0);
    drive_req(1, 2'b10, 64'hF, 64'h3, 0);
    @(negedge clk);
    check("rst_prio", {bus.req0_ready, bus.req1_ready}, 2'b10);
    if (bus.req0_ready) sbq.push_back(model(0, 2'b00, 64'd2, 64'd3));
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
